// File: rtl/shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// shared_mem_arbiter
//   Arbitrates a single-port unified memory between the instruction-fetch
//   stage and the MEM stage of a pipeline. One access is in flight at a time;
//   each access occupies the RAM for WAIT_CYCLES cycles and then completes
//   with a one-cycle valid pulse on the requesting port. Simultaneous
//   requests are granted alternately, with MEM winning the first tie after
//   reset.
//
// Parameters
//   WAIT_CYCLES  RAM access length in cycles (1..7)
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   if_req/if_addr                fetch request (level, held until if_valid)
//   if_rdata/if_valid             fetched word and completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata                     MEM-stage request (level, held until mem_valid)
//   mem_rdata/mem_valid           load data and completion pulse
//   ram_en/ram_we/ram_addr/
//   ram_wdata/ram_rdata           unified single-port memory interface
//   stall                         pipeline freeze while any request is pending
//   busy                          FSM is not idle
// -----------------------------------------------------------------------------
module shared_mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        stall,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY_IF,
    S_BUSY_MEM,
    S_RESP_IF,
    S_RESP_MEM
  } state_t;

  localparam logic [2:0] LP_CNT_LOAD = 3'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_last_mem;   // 1: last grant went to MEM, 0: to IF
  logic [31:0] r_if_rdata;
  logic        r_if_valid;
  logic [31:0] r_mem_rdata;
  logic        r_mem_valid;
  logic        r_ram_en;
  logic        r_ram_we;
  logic [31:0] r_ram_addr;
  logic [31:0] r_ram_wdata;

  logic        w_grant_mem;
  logic        w_grant_if;

  // On a tie the port that did not win last time is granted; a lone
  // request is granted regardless of history.
  assign w_grant_mem = mem_req & (~if_req | ~r_last_mem);
  assign w_grant_if  = if_req & ~w_grant_mem;

  // The ram_* registers double as the latched request: they are loaded at
  // grant, held through BUSY and cleared on leaving it, so inputs that
  // change mid-access have no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last_mem  <= 1'b0;
      r_if_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_mem_rdata <= '0;
      r_mem_valid <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_mem) begin
            r_state     <= S_BUSY_MEM;
            r_last_mem  <= 1'b1;
            r_cnt       <= LP_CNT_LOAD;
            r_ram_en    <= 1'b1;
            r_ram_we    <= mem_we;
            r_ram_addr  <= mem_addr;
            r_ram_wdata <= mem_wdata;
          end else if (w_grant_if) begin
            r_state     <= S_BUSY_IF;
            r_last_mem  <= 1'b0;
            r_cnt       <= LP_CNT_LOAD;
            r_ram_en    <= 1'b1;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= if_addr;
            r_ram_wdata <= '0;
          end
        end
        S_BUSY_IF: begin
          if (r_cnt == '0) begin
            r_state     <= S_RESP_IF;
            r_if_rdata  <= ram_rdata;
            r_if_valid  <= 1'b1;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_BUSY_MEM: begin
          if (r_cnt == '0) begin
            r_state     <= S_RESP_MEM;
            // A store leaves the previous load data visible.
            if (!r_ram_we) begin
              r_mem_rdata <= ram_rdata;
            end
            r_mem_valid <= 1'b1;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_RESP_IF: begin
          r_state    <= S_IDLE;
          r_if_valid <= 1'b0;
        end
        S_RESP_MEM: begin
          r_state     <= S_IDLE;
          r_mem_valid <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_if_valid  <= 1'b0;
          r_mem_valid <= 1'b0;
          r_ram_en    <= 1'b0;
          r_ram_we    <= 1'b0;
          r_ram_addr  <= '0;
          r_ram_wdata <= '0;
        end
      endcase
    end
  end

  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign mem_rdata = r_mem_rdata;
  assign mem_valid = r_mem_valid;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign busy      = (r_state != S_IDLE);
  assign stall     = (if_req & ~r_if_valid) | (mem_req & ~r_mem_valid);

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_mem_arbiter
//   Directed bench for shared_mem_arbiter. Cycle 0 of each scenario is the
//   cycle whose closing edge first sees the request; inputs change 1 time
//   unit after a rising edge or right after sampling, and outputs are sampled
//   on the falling edge. A second instance runs with WAIT_CYCLES = 1.
// -----------------------------------------------------------------------------
module tb_shared_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        stall;
  logic        busy;

  logic        w1_if_req = 1'b0;
  logic [31:0] w1_if_addr = '0;
  logic [31:0] w1_if_rdata;
  logic        w1_if_valid;
  logic        w1_mem_req = 1'b0;
  logic        w1_mem_we = 1'b0;
  logic [31:0] w1_mem_addr = '0;
  logic [31:0] w1_mem_wdata = '0;
  logic [31:0] w1_mem_rdata;
  logic        w1_mem_valid;
  logic        w1_ram_en;
  logic        w1_ram_we;
  logic [31:0] w1_ram_addr;
  logic [31:0] w1_ram_wdata;
  logic [31:0] w1_ram_rdata = '0;
  logic        w1_stall;
  logic        w1_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shared_mem_arbiter #(.WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall(stall), .busy(busy)
  );

  shared_mem_arbiter #(.WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst(rst),
    .if_req(w1_if_req), .if_addr(w1_if_addr), .if_rdata(w1_if_rdata), .if_valid(w1_if_valid),
    .mem_req(w1_mem_req), .mem_we(w1_mem_we), .mem_addr(w1_mem_addr), .mem_wdata(w1_mem_wdata),
    .mem_rdata(w1_mem_rdata), .mem_valid(w1_mem_valid),
    .ram_en(w1_ram_en), .ram_we(w1_ram_we), .ram_addr(w1_ram_addr), .ram_wdata(w1_ram_wdata),
    .ram_rdata(w1_ram_rdata), .stall(w1_stall), .busy(w1_busy)
  );

  task automatic test_reset();
    rst = 1'b1;
    #1;
    // No clock edge has occurred yet: the reset must act on its own.
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset.busy got %b exp 0", busy); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset.ram_en got %b exp 0", ram_en); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset.ram_we got %b exp 0", ram_we); end
    checks++; if (ram_addr !== 32'h0) begin errors++; $display("FAIL reset.ram_addr got %h exp 0", ram_addr); end
    checks++; if (ram_wdata !== 32'h0) begin errors++; $display("FAIL reset.ram_wdata got %h exp 0", ram_wdata); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset.if_valid got %b exp 0", if_valid); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset.mem_valid got %b exp 0", mem_valid); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL reset.if_rdata got %h exp 0", if_rdata); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset.mem_rdata got %h exp 0", mem_rdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset.stall got %b exp 0", stall); end
    checks++; if (w1_busy !== 1'b0) begin errors++; $display("FAIL reset.w1_busy got %b exp 0", w1_busy); end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset.busy_held got %b exp 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // First tie after reset goes to MEM, then IF follows.
  task automatic test_tie();
    logic        exp_en;
    logic [31:0] exp_addr;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h40;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    ram_rdata = 32'hAAAA_0100;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      exp_en   = (c == 1 || c == 2 || c == 5 || c == 6);
      exp_addr = (c == 1 || c == 2) ? 32'h100 : ((c == 5 || c == 6) ? 32'h40 : 32'h0);
      checks++; if (ram_en !== exp_en) begin errors++; $display("FAIL tie.ram_en c%0d got %b exp %b", c, ram_en, exp_en); end
      checks++; if (ram_addr !== exp_addr) begin errors++; $display("FAIL tie.ram_addr c%0d got %h exp %h", c, ram_addr, exp_addr); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL tie.ram_we c%0d got %b exp 0", c, ram_we); end
      checks++; if (mem_valid !== (c == 3)) begin errors++; $display("FAIL tie.mem_valid c%0d got %b exp %b", c, mem_valid, (c == 3)); end
      checks++; if (if_valid !== (c == 7)) begin errors++; $display("FAIL tie.if_valid c%0d got %b exp %b", c, if_valid, (c == 7)); end
      checks++; if (stall !== (c <= 6)) begin errors++; $display("FAIL tie.stall c%0d got %b exp %b", c, stall, (c <= 6)); end
      checks++; if (busy !== ((c >= 1 && c <= 3) || (c >= 5 && c <= 7))) begin errors++; $display("FAIL tie.busy c%0d got %b", c, busy); end
      if (c == 3) begin
        checks++; if (mem_rdata !== 32'hAAAA_0100) begin errors++; $display("FAIL tie.mem_rdata got %h exp aaaa0100", mem_rdata); end
        mem_req = 1'b0;
        ram_rdata = 32'hBBBB_0040;
      end
      if (c == 7) begin
        checks++; if (if_rdata !== 32'hBBBB_0040) begin errors++; $display("FAIL tie.if_rdata got %h exp bbbb0040", if_rdata); end
        if_req = 1'b0;
      end
      if (c == 8) begin
        checks++; if (mem_rdata !== 32'hAAAA_0100) begin errors++; $display("FAIL tie.mem_rdata_hold got %h exp aaaa0100", mem_rdata); end
      end
    end
  endtask

  // Both requests held: grants alternate MEM, IF, MEM, IF.
  task automatic test_back_to_back();
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        exp_mv;
    logic        exp_iv;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h40;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    ram_rdata = 32'h0B0B_0B0B;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      exp_en   = (c >= 1 && c <= 15) && (((c - 1) % 4) < 2);
      exp_addr = exp_en ? ((((c - 1) / 4) % 2 == 0) ? 32'h100 : 32'h40) : 32'h0;
      exp_mv   = (c == 3 || c == 11);
      exp_iv   = (c == 7 || c == 15);
      checks++; if (ram_en !== exp_en) begin errors++; $display("FAIL b2b.ram_en c%0d got %b exp %b", c, ram_en, exp_en); end
      checks++; if (ram_addr !== exp_addr) begin errors++; $display("FAIL b2b.ram_addr c%0d got %h exp %h", c, ram_addr, exp_addr); end
      checks++; if (mem_valid !== exp_mv) begin errors++; $display("FAIL b2b.mem_valid c%0d got %b exp %b", c, mem_valid, exp_mv); end
      checks++; if (if_valid !== exp_iv) begin errors++; $display("FAIL b2b.if_valid c%0d got %b exp %b", c, if_valid, exp_iv); end
      checks++; if (stall !== (c <= 15)) begin errors++; $display("FAIL b2b.stall c%0d got %b exp %b", c, stall, (c <= 15)); end
      if (c == 15) begin
        if_req = 1'b0;
        mem_req = 1'b0;
      end
    end
  endtask

  // Lone IF request right after an IF grant is still granted.
  task automatic test_if_only();
    logic        exp_en;
    logic [31:0] exp_addr;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h40;
    ram_rdata = 32'h2001_000A;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      exp_en   = (c == 1 || c == 2);
      exp_addr = exp_en ? 32'h40 : 32'h0;
      checks++; if (ram_en !== exp_en) begin errors++; $display("FAIL ifonly.ram_en c%0d got %b exp %b", c, ram_en, exp_en); end
      checks++; if (ram_addr !== exp_addr) begin errors++; $display("FAIL ifonly.ram_addr c%0d got %h exp %h", c, ram_addr, exp_addr); end
      checks++; if (if_valid !== (c == 3)) begin errors++; $display("FAIL ifonly.if_valid c%0d got %b exp %b", c, if_valid, (c == 3)); end
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL ifonly.mem_valid c%0d got %b exp 0", c, mem_valid); end
      checks++; if (stall !== (c <= 2)) begin errors++; $display("FAIL ifonly.stall c%0d got %b exp %b", c, stall, (c <= 2)); end
      if (c == 3) begin
        checks++; if (if_rdata !== 32'h2001_000A) begin errors++; $display("FAIL ifonly.if_rdata got %h exp 2001000a", if_rdata); end
        if_req = 1'b0;
      end
    end
  endtask

  // Store: write strobes from latched values, load data left untouched.
  task automatic test_store();
    logic        exp_en;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
    ram_rdata = 32'h5555_5555;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      exp_en = (c == 1 || c == 2);
      checks++; if (ram_en !== exp_en) begin errors++; $display("FAIL store.ram_en c%0d got %b exp %b", c, ram_en, exp_en); end
      checks++; if (ram_we !== exp_en) begin errors++; $display("FAIL store.ram_we c%0d got %b exp %b", c, ram_we, exp_en); end
      checks++; if (ram_addr !== (exp_en ? 32'h100 : 32'h0)) begin errors++; $display("FAIL store.ram_addr c%0d got %h", c, ram_addr); end
      checks++; if (ram_wdata !== (exp_en ? 32'hDEAD_BEEF : 32'h0)) begin errors++; $display("FAIL store.ram_wdata c%0d got %h", c, ram_wdata); end
      checks++; if (mem_valid !== (c == 3)) begin errors++; $display("FAIL store.mem_valid c%0d got %b exp %b", c, mem_valid, (c == 3)); end
      checks++; if (mem_rdata !== 32'h0B0B_0B0B) begin errors++; $display("FAIL store.mem_rdata c%0d got %h exp 0b0b0b0b", c, mem_rdata); end
      if (c == 1) begin
        // Mid-access input changes must not reach the RAM.
        mem_we = 1'b0; mem_addr = 32'h300; mem_wdata = 32'h1234_5678;
      end
      if (c == 3) begin
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h100; mem_wdata = '0;
      end
    end
  endtask

  // Reset in the middle of a MEM access, then the same request completes.
  task automatic test_reset_busy();
    logic exp_en;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200;
    ram_rdata = 32'h7777_0200;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      checks++; if (ram_en !== (c >= 1)) begin errors++; $display("FAIL rstbusy.ram_en_pre c%0d got %b exp %b", c, ram_en, (c >= 1)); end
    end
    #1 rst = 1'b1;
    #1;
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rstbusy.ram_en got %b exp 0", ram_en); end
    checks++; if (ram_addr !== 32'h0) begin errors++; $display("FAIL rstbusy.ram_addr got %h exp 0", ram_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstbusy.busy got %b exp 0", busy); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rstbusy.mem_valid got %b exp 0", mem_valid); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rstbusy.mem_rdata got %h exp 0", mem_rdata); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL rstbusy.if_rdata got %h exp 0", if_rdata); end
    #1 rst = 1'b0;
    // The edge closing cycle 2 now sees the held request in IDLE.
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      exp_en = (c == 3 || c == 4);
      checks++; if (ram_en !== exp_en) begin errors++; $display("FAIL rstbusy.ram_en_post c%0d got %b exp %b", c, ram_en, exp_en); end
      checks++; if (mem_valid !== (c == 5)) begin errors++; $display("FAIL rstbusy.mem_valid_post c%0d got %b exp %b", c, mem_valid, (c == 5)); end
      if (c == 5) begin
        checks++; if (mem_rdata !== 32'h7777_0200) begin errors++; $display("FAIL rstbusy.mem_rdata_post got %h exp 77770200", mem_rdata); end
        mem_req = 1'b0;
      end
    end
  endtask

  // Shortest access on the WAIT_CYCLES = 1 instance.
  task automatic test_wait1();
    logic exp_en;
    @(posedge clk); #1;
    w1_if_req = 1'b1; w1_if_addr = 32'h80;
    w1_ram_rdata = 32'hCAFE_F00D;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      exp_en = (c == 1);
      checks++; if (w1_ram_en !== exp_en) begin errors++; $display("FAIL w1.ram_en c%0d got %b exp %b", c, w1_ram_en, exp_en); end
      checks++; if (w1_ram_addr !== (exp_en ? 32'h80 : 32'h0)) begin errors++; $display("FAIL w1.ram_addr c%0d got %h", c, w1_ram_addr); end
      checks++; if (w1_if_valid !== (c == 2)) begin errors++; $display("FAIL w1.if_valid c%0d got %b exp %b", c, w1_if_valid, (c == 2)); end
      checks++; if (w1_busy !== (c == 1 || c == 2)) begin errors++; $display("FAIL w1.busy c%0d got %b", c, w1_busy); end
      if (c == 2) begin
        checks++; if (w1_if_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL w1.if_rdata got %h exp cafef00d", w1_if_rdata); end
        w1_if_req = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_back_to_back();
    test_if_only();
    test_store();
    test_reset_busy();
    test_wait1();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_mem_arbiter.md
SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, RAM access length in cycles; legal range 1..7.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port if_req  input  1  fetch stage read request, level, held until if_valid.
REQ-005 SHALL have port if_addr  input  32  fetch address (PC).
REQ-006 SHALL have port if_rdata  output  32  fetched instruction word.
REQ-007 SHALL have port if_valid  output  1  one-cycle completion pulse for fetch.
REQ-008 SHALL have port mem_req  input  1  MEM-stage request, level, held until mem_valid.
REQ-009 SHALL have port mem_we  input  1  1 = store, 0 = load.
REQ-010 SHALL have port mem_addr  input  32  data address (ALU result).
REQ-011 SHALL have port mem_wdata  input  32  store data.
REQ-012 SHALL have port mem_rdata  output  32  load data.
REQ-013 SHALL have port mem_valid  output  1  one-cycle completion pulse for MEM stage.
REQ-014 SHALL have ports ram_en, ram_we (output 1), ram_addr, ram_wdata (output 32), ram_rdata (input 32) to the single-port unified memory.
REQ-015 SHALL have port stall  output  1  pipeline freeze request.
REQ-016 SHALL have port busy  output  1  high when FSM not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY_IF, BUSY_MEM, RESP_IF, RESP_MEM.
REQ-018 SHALL arbitrate only in IDLE; a request present in IDLE at an edge moves FSM to BUSY_x, latches addr/we/wdata, loads counter with WAIT_CYCLES-1.
REQ-019 SHALL, when both requests present in IDLE, grant the port not granted last; after reset the first tie goes to MEM.
REQ-020 SHALL, with one request present, grant it regardless of last-grant history.
REQ-021 SHALL drive ram_en=1 and ram_addr/ram_we/ram_wdata from latched values throughout BUSY_x, ram_we=1 only for a MEM store; in all other states ram_en=ram_we=0, ram_addr=ram_wdata=0.
REQ-022 SHALL decrement counter each BUSY cycle; on the edge with counter=0, capture ram_rdata (loads and fetches only) and move to RESP_x.
REQ-023 SHALL assert x_valid for exactly the RESP_x cycle, then return to IDLE.
REQ-024 SHALL give latency: request seen in IDLE cycle N -> ram_en cycles N+1..N+WAIT_CYCLES -> x_valid cycle N+WAIT_CYCLES+1; max throughput one access per WAIT_CYCLES+2 cycles.
REQ-025 SHALL leave mem_rdata unchanged on a store completion; if_rdata/mem_rdata hold until the next completion on that port.
REQ-026 SHALL not abort an access when its request drops mid-BUSY: access completes, x_valid still pulses.
REQ-027 SHALL ignore input changes on addr/we/wdata during BUSY (latched values used).
REQ-028 SHALL drive stall = (if_req & ~if_valid) | (mem_req & ~mem_valid), combinational.
REQ-029 SHALL never assert if_valid and mem_valid in the same cycle.

Reset
REQ-030 SHALL on rst, immediately and independent of clk: FSM=IDLE, counter=0, last-grant=IF (so MEM wins first tie), if_rdata=mem_rdata=0, if_valid=mem_valid=0, ram_en=ram_we=0, busy=0.
REQ-031 SHALL abandon any in-flight access on reset with no valid pulse; first request after release sees normal REQ-024 latency.

Verification
REQ-032 IF-only, WAIT_CYCLES=2: if_req=1, if_addr=0x40 at cycle 0, ram_rdata=0x2001000A -> ram_en cycles 1-2 addr 0x40, if_valid cycle 3, if_rdata=0x2001000A, stall high cycles 0-2.
REQ-033 Tie: if_req and mem_req (load 0x100) both rise cycle 0 -> mem_valid cycle 3, ram_addr 0x40 cycles 5-6, if_valid cycle 7.
REQ-034 Both held continuously over 4 accesses -> grant order MEM, IF, MEM, IF; valids at cycles 3, 7, 11, 15.
REQ-035 Store: mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF -> ram_we=1 cycles 1-2 with those values, mem_valid cycle 3, mem_rdata unchanged.
REQ-036 rst pulsed during BUSY_MEM cycle 2 -> ram_en low same instant, no mem_valid; request re-presented after release completes WAIT_CYCLES+1 cycles later.
REQ-037 WAIT_CYCLES=1: single IF read at cycle 0 -> ram_en cycle 1 only, if_valid cycle 2.
